data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words stored; power of two.
REQ-002 Parameter LATENCY, default 3: cycles from request acceptance to response; legal range 1..15.
REQ-003 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 req_i  input  1  initiator requests an access this cycle.
REQ-006 we_i  input  1  1 = write, 0 = read; qualified by req_i.
REQ-007 be_i  input  4  byte-enables for writes; bit n covers wdata_i[8n+7:8n].
REQ-008 addr_i  input  32  byte address.
REQ-009 wdata_i  input  32  write data.
REQ-010 ready_o  output  1  responder can accept a request this cycle.
REQ-011 ack_o  output  1  one-cycle response strobe.
REQ-012 rdata_o  output  32  read data; valid only while ack_o=1.
REQ-013 err_o  output  1  error flag; valid only while ack_o=1.

Function
REQ-014 States: IDLE, WAIT, RESP; reset state IDLE.
REQ-015 ready_o = 1 in IDLE and RESP; 0 in WAIT.
REQ-016 Acceptance happens on a rising edge where req_i=1 and ready_o=1; we_i, be_i, addr_i and wdata_i are captured on that edge.
REQ-017 req_i while ready_o=0 is ignored; the initiator holds it until accepted.
REQ-018 Acceptance with LATENCY=1 goes to RESP; with LATENCY>1 it goes to WAIT and loads a down-counter with LATENCY-1.
REQ-019 WAIT decrements the counter each cycle and moves to RESP on the edge where the counter is 1.
REQ-020 ack_o=1 for exactly one cycle (the RESP cycle), which is sampled at the LATENCY-th edge after the acceptance edge.
REQ-021 In RESP, a new acceptance proceeds per REQ-018; with no request the next state is IDLE.
REQ-022 Sustained throughput is one access per LATENCY cycles.
REQ-023 Error condition: addr_i[1:0]!=0 or word index addr_i[31:2] >= DEPTH_WORDS.
REQ-024 An erroneous access returns err_o=1 and rdata_o=0 and modifies no storage.
REQ-025 A write commits only enabled bytes, on the edge entering RESP, to word addr[31:2].
REQ-026 A write response has rdata_o=0 and err_o=0.
REQ-027 A read returns the word at addr[31:2] as it stands on the edge entering RESP, so any earlier committed write is visible.
REQ-028 A write with be_i=0 is a legal no-op that still acks.
REQ-029 rdata_o and err_o are 0 in every non-RESP cycle.

Reset
REQ-030 While rst_i=1: state IDLE, counter 0, ack_o=0, err_o=0, rdata_o=0, ready_o=0.
REQ-031 ready_o=1 from the first cycle after rst_i deasserts.
REQ-032 Reset mid-WAIT aborts the access with no ack; a pending write is not committed.
REQ-033 Storage contents are not cleared by reset.

Structure
REQ-034 Package dmem_pkg holds the state enum (IDLE/WAIT/RESP), the counter width constant (4), and the error-check function.
REQ-035 Storage is a separate sub-module dmem_array: synchronous byte-enabled write, combinational read, no reset.

Verification
REQ-036 Reset, then write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 (LATENCY=3) -> each ack comes 3 edges after acceptance; read rdata_o=0xDEADBEEF, err_o=0.
REQ-037 Write 0x11223344 to 0x20 be=F, then 0xAABBCCDD be=4'b0101, then read 0x20 -> 0x11BB33DD.
REQ-038 Read 0x22 (misaligned) and read 0x400 (DEPTH 256) -> ack with err_o=1, rdata_o=0; a following read of 0x0 is unaffected.
REQ-039 req_i held high continuously with LATENCY=1 -> ack_o high every cycle, ready_o never low; with LATENCY=3 -> one ack every 3 cycles, ready_o low 2 of every 3 cycles.
REQ-040 Issue write 0x55 to 0x8, assert rst_i 1 cycle after acceptance -> no ack; a later read of 0x8 returns the prior value, not 0x55.
REQ-041 Write to 0x4 accepted in a RESP cycle while the previous read of 0x4 acks -> the read returns the old value; a following read returns the new value.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int CNT_W = 4;

    // Misaligned byte addresses and word indices past the array are both errors.
    function automatic logic addr_error(input logic [31:0] addr, input logic [31:0] depth_words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous byte-enabled write, combinational read, never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder: accepts one access, answers LATENCY cycles later.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t           state, next_state;
    logic [CNT_W-1:0] count, next_count;

    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic        enter_resp;
    logic        acc_we;
    logic [3:0]  acc_be;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_err;
    logic        commit;
    logic [31:0] mem_rdata;
    logic [31:0] rdata_q;
    logic        err_q;

    assign ready_o = !rst_i && (state != WAIT);
    assign accept  = req_i && ready_o;

    always_comb begin
        next_state = state;
        next_count = count;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                        next_count = CNT_W'(LATENCY - 1);
                    end
                end else begin
                    next_state = IDLE;
                end
            end
            WAIT: begin
                if (count == CNT_W'(1)) begin
                    next_state = RESP;
                    next_count = '0;
                end else begin
                    next_count = count - CNT_W'(1);
                end
            end
            default: begin
                next_state = IDLE;
                next_count = '0;
            end
        endcase
    end

    // With LATENCY=1 the access enters RESP on its own acceptance edge, so the
    // live inputs are used; otherwise the captured copy from WAIT is used.
    assign acc_we     = (state == WAIT) ? we_q    : we_i;
    assign acc_be     = (state == WAIT) ? be_q    : be_i;
    assign acc_addr   = (state == WAIT) ? addr_q  : addr_i;
    assign acc_wdata  = (state == WAIT) ? wdata_q : wdata_i;
    assign acc_err    = addr_error(acc_addr, 32'(DEPTH_WORDS));
    assign enter_resp = (next_state == RESP);
    assign commit     = enter_resp && acc_we && !acc_err && !rst_i;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk_i),
        .we   (commit),
        .be   (acc_be),
        .addr (acc_addr[AW+1:2]),
        .wdata(acc_wdata),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            count   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= next_state;
            count <= next_count;
            if (enter_resp) begin
                err_q   <= acc_err;
                rdata_q <= (acc_err || acc_we) ? 32'h0 : mem_rdata;
            end else begin
                err_q   <= 1'b0;
                rdata_q <= 32'h0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            we_q    <= we_i;
            be_q    <= be_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
        end
    end

    assign ack_o   = !rst_i && (state == RESP);
    assign rdata_o = rst_i ? 32'h0 : rdata_q;
    assign err_o   = rst_i ? 1'b0  : err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at LATENCY=3 and LATENCY=1.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic        ready, ack, err;
    logic [31:0] rdata;

    logic        req1, we1;
    logic [3:0]  be1;
    logic [31:0] addr1, wdata1;
    logic        ready1, ack1, err1;
    logic [31:0] rdata1;

    int checks = 0;
    int passes = 0;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .ready_o(ready), .ack_o(ack),
        .rdata_o(rdata), .err_o(err)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we1), .be_i(be1),
        .addr_i(addr1), .wdata_i(wdata1), .ready_o(ready1), .ack_o(ack1),
        .rdata_o(rdata1), .err_o(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issues one access on the LATENCY=3 instance and returns its response and latency in edges.
    task automatic apply_stimulus(input logic w, input logic [3:0] b, input logic [31:0] a,
                                  input logic [31:0] d, output logic [31:0] rd,
                                  output logic er, output int lat);
        int guard;
        @(negedge clk);
        req = 1'b1; we = w; be = b; addr = a; wdata = d;
        guard = 0;
        while (!ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        req = 1'b0;
        while (!ack && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rd = rdata;
        er = err;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          g;
        int          acks, lows, seen;

        rst = 1'b1;
        req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
        req1 = 1'b0; we1 = 1'b0; be1 = 4'h0; addr1 = 32'h0; wdata1 = 32'h0;

        @(negedge clk);
        check_output("reset ready", 32'(ready), 32'h0);
        check_output("reset ack", 32'(ack), 32'h0);
        check_output("reset rdata", rdata, 32'h0);
        check_output("reset err", 32'(err), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check_output("ready after reset", 32'(ready), 32'h1);

        apply_stimulus(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, er, lat);
        check_output("write latency", 32'(lat), 32'd3);
        check_output("write rdata", rd, 32'h0);
        check_output("write err", 32'(er), 32'h0);
        apply_stimulus(1'b0, 4'hF, 32'h10, 32'h0, rd, er, lat);
        check_output("read latency", 32'(lat), 32'd3);
        check_output("read 0x10", rd, 32'hDEADBEEF);
        check_output("read err", 32'(er), 32'h0);
        @(negedge clk);
        check_output("ack single cycle", 32'(ack), 32'h0);
        check_output("rdata idle zero", rdata, 32'h0);

        apply_stimulus(1'b1, 4'hF, 32'h20, 32'h11223344, rd, er, lat);
        apply_stimulus(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, rd, er, lat);
        apply_stimulus(1'b0, 4'hF, 32'h20, 32'h0, rd, er, lat);
        check_output("byte enable merge", rd, 32'h11BB33DD);

        apply_stimulus(1'b1, 4'hF, 32'h0, 32'hCAFEF00D, rd, er, lat);
        apply_stimulus(1'b0, 4'hF, 32'h22, 32'h0, rd, er, lat);
        check_output("misaligned err", 32'(er), 32'h1);
        check_output("misaligned rdata", rd, 32'h0);
        apply_stimulus(1'b0, 4'hF, 32'h400, 32'h0, rd, er, lat);
        check_output("range err", 32'(er), 32'h1);
        check_output("range rdata", rd, 32'h0);
        apply_stimulus(1'b1, 4'hF, 32'h2, 32'hFFFFFFFF, rd, er, lat);
        check_output("misaligned write err", 32'(er), 32'h1);
        apply_stimulus(1'b1, 4'hF, 32'h400, 32'h12345678, rd, er, lat);
        check_output("range write err", 32'(er), 32'h1);
        apply_stimulus(1'b0, 4'hF, 32'h0, 32'h0, rd, er, lat);
        check_output("read 0x0 unaffected", rd, 32'hCAFEF00D);
        check_output("read 0x0 err", 32'(er), 32'h0);

        apply_stimulus(1'b1, 4'h0, 32'h10, 32'h0BAD0BAD, rd, er, lat);
        check_output("be0 write latency", 32'(lat), 32'd3);
        check_output("be0 write err", 32'(er), 32'h0);
        apply_stimulus(1'b0, 4'hF, 32'h10, 32'h0, rd, er, lat);
        check_output("be0 no change", rd, 32'hDEADBEEF);

        apply_stimulus(1'b1, 4'hF, 32'h8, 32'h0BADF00D, rd, er, lat);
        @(negedge clk);
        req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h8; wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (ack) seen++;
            if (i == 2) rst = 1'b0;
            @(negedge clk);
        end
        check_output("no ack after abort", 32'(seen), 32'h0);
        apply_stimulus(1'b0, 4'hF, 32'h8, 32'h0, rd, er, lat);
        check_output("aborted write dropped", rd, 32'h0BADF00D);

        apply_stimulus(1'b1, 4'hF, 32'h4, 32'h01010101, rd, er, lat);
        @(negedge clk);
        req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h4; wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        we = 1'b1; wdata = 32'h02020202;
        g = 0;
        while (!ack && g < 20) begin
            @(negedge clk);
            g++;
        end
        check_output("overlap read old", rdata, 32'h01010101);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        req = 1'b0;
        while (!ack && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_output("overlap write latency", 32'(lat), 32'd3);
        apply_stimulus(1'b0, 4'hF, 32'h4, 32'h0, rd, er, lat);
        check_output("overlap read new", rd, 32'h02020202);

        @(negedge clk);
        req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h10;
        @(posedge clk);
        acks = 0; lows = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (ack) acks++;
            if (!ready) lows++;
        end
        req = 1'b0;
        check_output("lat3 stream acks", 32'(acks), 32'd3);
        check_output("lat3 stream ready low", 32'(lows), 32'd6);
        @(negedge clk);

        req1 = 1'b1; we1 = 1'b1; be1 = 4'hF; addr1 = 32'hC; wdata1 = 32'h600DCAFE;
        @(posedge clk);
        @(negedge clk);
        check_output("lat1 write ack", 32'(ack1), 32'h1);
        we1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_output("lat1 read ack", 32'(ack1), 32'h1);
        check_output("lat1 read data", rdata1, 32'h600DCAFE);
        acks = 0; lows = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack1) acks++;
            if (!ready1) lows++;
        end
        req1 = 1'b0;
        check_output("lat1 stream acks", 32'(acks), 32'd6);
        check_output("lat1 stream ready low", 32'(lows), 32'd0);
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
